fetch_prefetch: RTL and testbench

Instruction prefetcher that sits directly upstream of the boot ROM / instruction memory. It issues word-read requests on a request/ready port with one outstanding access, and buffers returned words with their PCs in a small FIFO. It presents them to the decode stage through a valid/ready handshake. A redirect (branch/trap/jump) flushes buffered and in-flight words and restarts fetch at a new PC.

---
 rtl/fetch_prefetch.sv | 138 +++++++++++++
 tb/tb_fetch_prefetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: one outstanding word read at a time, returned words
// queued with their PCs in a small FIFO for decode; a redirect flushes and restarts.
module fetch_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    output logic        o_bus_request,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    input  logic        i_ready
);

    localparam int            PW         = $clog2(DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic          discard;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0]   redirect_pc;
    logic          completion;
    logic          push;
    logic          pop;
    logic          unused_redirect_bits;

    assign redirect_pc          = {i_redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^i_redirect_pc[1:0];

    // A completion is dropped when it belongs to a fetch made stale by a redirect,
    // either earlier in this access or in the very cycle it completes.
    assign completion = (state == ST_REQUEST) && i_bus_ready;
    assign push       = completion && !discard && !i_redirect;
    assign pop        = o_valid && i_ready;

    assign o_valid       = (count != '0);
    assign o_instruction = instr_mem[rd_ptr];
    assign o_pc          = pc_mem[rd_ptr];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ST_IDLE;
            o_bus_request <= 1'b0;
            o_bus_address <= RESET_PC;
            fetch_pc      <= RESET_PC;
            discard       <= 1'b0;
        end else begin
            unique case (state)
                // A redirect seen in IDLE holds off one cycle so the new PC is used.
                ST_IDLE: begin
                    if (i_redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (count < FULL_COUNT) begin
                        state         <= ST_REQUEST;
                        o_bus_request <= 1'b1;
                        o_bus_address <= fetch_pc;
                    end
                end
                ST_REQUEST: begin
                    if (i_bus_ready) begin
                        state         <= ST_DRAIN;
                        o_bus_request <= 1'b0;
                        discard       <= 1'b0;
                        if (i_redirect) begin
                            fetch_pc <= redirect_pc;
                        end else if (!discard) begin
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                    end else if (i_redirect) begin
                        discard  <= 1'b1;
                        fetch_pc <= redirect_pc;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_IDLE;
                    if (i_redirect) begin
                        fetch_pc <= redirect_pc;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    o_bus_request <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (i_redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= i_bus_rdata;
                pc_mem[wr_ptr]    <= o_bus_address;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: bench-side memory with adjustable latency, a queue-based
// reference model compared every cycle, and directed checks on accepted PCs.
module tb_fetch_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        o_bus_request;
    logic [31:0] o_bus_address;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ready;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        i_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    fetch_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .o_bus_request (o_bus_request),
        .o_bus_address (o_bus_address),
        .i_bus_rdata   (i_bus_rdata),
        .i_bus_ready   (i_bus_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .i_ready       (i_ready)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h1000_0093;
        if (addr == 32'h4) return 32'h0020_0113;
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Memory keeps ready high while the request stays high, so the DRAIN cycle
    // always sees a stray ready carrying junk data.
    int          mem_lat = 1;
    int          req_age = 0;
    logic        mem_ready = 1'b0;
    logic        stray_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    assign i_bus_ready = mem_ready | stray_ready;
    assign i_bus_rdata = mem_rdata;

    always @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            req_age   <= 0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else if (o_bus_request) begin
            req_age   <= req_age + 1;
            mem_ready <= (req_age + 1) >= mem_lat;
            mem_rdata <= ((req_age + 1) == mem_lat) ? rom_word(o_bus_address) : 32'hDEAD_BEEF;
        end else begin
            req_age   <= 0;
            mem_ready <= 1'b0;
        end
    end

    // Reference model: FIFO contents as queues, one pending access, a cooldown after it.
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    logic        m_req = 1'b0;
    logic [31:0] m_addr = RESET_PC;
    logic [31:0] m_pc = RESET_PC;
    logic        m_discard = 1'b0;
    int          m_cool = 0;

    initial forever begin
        @(posedge i_clock or negedge i_reset_n);
        if (!i_reset_n) begin
            q_pc.delete();
            q_instr.delete();
            m_req     = 1'b0;
            m_addr    = RESET_PC;
            m_pc      = RESET_PC;
            m_discard = 1'b0;
            m_cool    = 0;
        end else begin
            int sz;
            bit do_pop;
            bit do_push;
            sz      = q_pc.size();
            do_pop  = (sz != 0) && i_ready;
            do_push = 1'b0;
            if (m_req) begin
                if (i_bus_ready) begin
                    do_push   = !m_discard && !i_redirect;
                    if (do_push) m_pc = m_pc + 32'd4;
                    m_req     = 1'b0;
                    m_discard = 1'b0;
                    m_cool    = 1;
                end else if (i_redirect) begin
                    m_discard = 1'b1;
                end
            end else if (m_cool > 0) begin
                m_cool = m_cool - 1;
            end else if (!i_redirect && sz < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_pc;
            end
            if (i_redirect) begin
                q_pc.delete();
                q_instr.delete();
                m_pc = {i_redirect_pc[31:2], 2'b00};
            end else begin
                if (do_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_instr.pop_front());
                end
                if (do_push) begin
                    q_pc.push_back(m_addr);
                    q_instr.push_back(rom_word(m_addr));
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    logic [31:0] log_pc[$];
    logic [31:0] log_instr[$];

    initial forever begin
        @(negedge i_clock);
        check_output("o_valid", 32'(o_valid), 32'(q_pc.size() != 0));
        check_output("o_bus_request", 32'(o_bus_request), 32'(m_req));
        check_output("o_bus_address", o_bus_address, m_addr);
        if (q_pc.size() != 0) begin
            check_output("o_pc", o_pc, q_pc[0]);
            check_output("o_instruction", o_instruction, q_instr[0]);
        end
        if (o_valid && i_ready) begin
            log_pc.push_back(o_pc);
            log_instr.push_back(o_instruction);
        end
    end

    task automatic step();
        @(posedge i_clock);
        #2;
    endtask

    task automatic apply_stimulus(input logic redirect, input logic [31:0] pc, input logic ready);
        i_redirect    = redirect;
        i_redirect_pc = pc;
        i_ready       = ready;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        apply_stimulus(1'b1, pc, i_ready);
        step();
        i_redirect = 1'b0;
    endtask

    task automatic wait_bus_idle();
        int n = 0;
        while ((o_bus_request || i_bus_ready) && n < 40) begin
            step();
            n++;
        end
        if (o_bus_request || i_bus_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_bus_idle timeout at %0t", $time);
        end
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (log_pc.size() < target && n < budget) begin
            step();
            n++;
        end
        if (log_pc.size() < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_pops got=%0d wanted=%0d at %0t", log_pc.size(), target, $time);
        end
    endtask

    task automatic check_pop(input string name, input int idx, input logic [31:0] exp_pc);
        if (idx < log_pc.size()) begin
            check_output(name, log_pc[idx], exp_pc);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL %s no pop at index %0d expected pc=%h", name, idx, exp_pc);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cycles;
        int          idx;
        logic [31:0] max_addr;

        // Reset and first words from RESET_PC
        apply_stimulus(1'b0, '0, 1'b1);
        repeat (3) step();
        check_output("reset_request", 32'(o_bus_request), 32'd0);
        check_output("reset_address", o_bus_address, RESET_PC);
        check_output("reset_valid", 32'(o_valid), 32'd0);
        check_output("reset_instruction", o_instruction, 32'd0);
        check_output("reset_pc", o_pc, 32'd0);
        i_reset_n = 1'b1;
        cycles = 0;
        while (!o_valid && cycles < 20) begin
            step();
            cycles++;
        end
        check_output("first_valid_within_5", 32'(o_valid && cycles <= 5), 32'd1);
        wait_pops(3, 40);
        check_pop("seq_pc0", 0, 32'h0);
        check_pop("seq_pc1", 1, 32'h4);
        check_pop("seq_pc2", 2, 32'h8);
        if (log_instr.size() >= 2) begin
            check_output("seq_word0", log_instr[0], 32'h1000_0093);
            check_output("seq_word1", log_instr[1], 32'h0020_0113);
        end

        // Back-pressure fills the FIFO and fetch stops
        wait_bus_idle();
        i_ready = 1'b0;
        redirect_to(32'h0);
        max_addr = '0;
        repeat (40) begin
            step();
            if (o_bus_request && o_bus_address > max_addr) max_addr = o_bus_address;
        end
        check_output("full_max_address", max_addr, 32'hC);
        check_output("full_request_idle", 32'(o_bus_request), 32'd0);
        check_output("full_valid", 32'(o_valid), 32'd1);
        idx = log_pc.size();
        i_ready = 1'b1;
        wait_pops(idx + 5, 60);
        check_pop("full_pc0", idx, 32'h0);
        check_pop("full_pc1", idx + 1, 32'h4);
        check_pop("full_pc2", idx + 2, 32'h8);
        check_pop("full_pc3", idx + 3, 32'hC);
        check_pop("full_resume", idx + 4, 32'h10);

        // Redirect while a request at 0x8 is outstanding
        wait_bus_idle();
        redirect_to(32'h0);
        cycles = 0;
        while (!(o_bus_request && o_bus_address == 32'h8) && cycles < 40) begin
            step();
            cycles++;
        end
        check_output("reached_request_8", 32'(o_bus_request && o_bus_address == 32'h8), 32'd1);
        redirect_to(32'h0000_0103);
        idx = log_pc.size();
        wait_pops(idx + 2, 40);
        check_pop("redirect_pc0", idx, 32'h100);
        check_pop("redirect_pc1", idx + 1, 32'h104);

        // Redirect coinciding with a push and a pop
        wait_bus_idle();
        i_ready = 1'b0;
        redirect_to(32'h180);
        cycles = 0;
        while (!(o_bus_request && i_bus_ready && o_valid) && cycles < 40) begin
            step();
            cycles++;
        end
        check_output("reached_push_pop", 32'(o_bus_request && i_bus_ready && o_valid), 32'd1);
        apply_stimulus(1'b1, 32'h200, 1'b1);
        step();
        i_redirect = 1'b0;
        check_output("flush_valid", 32'(o_valid), 32'd0);
        idx = log_pc.size();
        wait_pops(idx + 1, 40);
        check_pop("flush_next_pc", idx, 32'h200);

        // Address wrap
        wait_bus_idle();
        redirect_to(32'hFFFF_FFF8);
        idx = log_pc.size();
        wait_pops(idx + 3, 40);
        check_pop("wrap_pc0", idx, 32'hFFFF_FFF8);
        check_pop("wrap_pc1", idx + 1, 32'hFFFF_FFFC);
        check_pop("wrap_pc2", idx + 2, 32'h0);

        // Slow memory
        wait_bus_idle();
        mem_lat = 3;
        redirect_to(32'h40);
        idx = log_pc.size();
        wait_pops(idx + 3, 80);
        check_pop("slow_pc0", idx, 32'h40);
        check_pop("slow_pc1", idx + 1, 32'h44);
        check_pop("slow_pc2", idx + 2, 32'h48);

        // Randomised traffic
        for (int seg = 0; seg < 6; seg++) begin
            wait_bus_idle();
            mem_lat = $urandom_range(1, 3);
            repeat (300) begin
                if ($urandom_range(0, 39) == 0) begin
                    apply_stimulus(1'b1, $urandom, ($urandom_range(0, 3) != 0));
                end else begin
                    apply_stimulus(1'b0, i_redirect_pc, ($urandom_range(0, 3) != 0));
                end
                step();
            end
            i_redirect = 1'b0;
        end

        // Reset mid-access followed by a late ready
        wait_bus_idle();
        mem_lat = 3;
        i_ready = 1'b1;
        redirect_to(32'h80);
        cycles = 0;
        while (!o_bus_request && cycles < 40) begin
            step();
            cycles++;
        end
        step();
        i_reset_n = 1'b0;
        step();
        check_output("midreset_request", 32'(o_bus_request), 32'd0);
        check_output("midreset_address", o_bus_address, RESET_PC);
        check_output("midreset_valid", 32'(o_valid), 32'd0);
        i_reset_n   = 1'b1;
        stray_ready = 1'b1;
        step();
        stray_ready = 1'b0;
        check_output("after_reset_request", 32'(o_bus_request), 32'd1);
        check_output("after_reset_address", o_bus_address, RESET_PC);
        check_output("after_reset_valid", 32'(o_valid), 32'd0);
        idx = log_pc.size();
        wait_pops(idx + 1, 40);
        check_pop("after_reset_pc", idx, RESET_PC);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
